// File: rtl/cmprs_fifo_pkg.sv
// rtl/cmprs_fifo_pkg.sv - address/pointer width helpers shared by the chunk FIFO files
package cmprs_fifo_pkg;

  // Write-side address: one index per write word over the whole buffer.
  function automatic int wa_bits(input int log2width_wr, input int log2chunk_bytes,
                                 input int log2depth_chunks);
    return log2depth_chunks + log2chunk_bytes + 3 - log2width_wr;
  endfunction

  // Read-side address: one index per 64-bit word over the whole buffer.
  function automatic int ra_bits(input int log2chunk_bytes, input int log2depth_chunks);
    return log2depth_chunks + log2chunk_bytes - 3;
  endfunction

  // Chunk pointers carry one extra wrap bit so full and empty differ.
  function automatic int ptr_bits(input int log2depth_chunks);
    return log2depth_chunks + 1;
  endfunction

  // Low address bits that select a write word inside a chunk.
  function automatic int wsub_bits(input int log2width_wr, input int log2chunk_bytes);
    return log2chunk_bytes + 3 - log2width_wr;
  endfunction

  // Low address bits that select a 64-bit word inside a chunk.
  function automatic int rsub_bits(input int log2chunk_bytes);
    return log2chunk_bytes - 3;
  endfunction

endpackage

// File: rtl/cmprs_chunk_ram.sv
// rtl/cmprs_chunk_ram.sv - simple dual-port RAM, narrow write, 64-bit read, two-stage read pipe
// Ports:
//   clk            single clock
//   we/waddr/wdata write one (1<<LOG2WIDTH_WR)-bit word
//   re/raddr       load the RAM output register with one 64-bit word
//   regen          move the RAM output register into rdata
//   rdata          64-bit read data; write word 0 of a group sits in the low bits
module cmprs_chunk_ram #(
  parameter int LOG2WIDTH_WR = 4,
  parameter int WA           = 11,
  parameter int RA           = 9
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [WA-1:0]                waddr,
  input  logic [(1<<LOG2WIDTH_WR)-1:0] wdata,
  input  logic                         re,
  input  logic [RA-1:0]                raddr,
  input  logic                         regen,
  output logic [63:0]                  rdata
);
  localparam int WW    = 1 << LOG2WIDTH_WR;
  localparam int RATIO = 64 / WW;
  localparam int SH    = 6 - LOG2WIDTH_WR;

  logic [WW-1:0] mem [1<<WA];
  logic [63:0]   gather;
  logic [63:0]   ram_d, ram_q;
  logic [63:0]   rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A 64-bit read covers RATIO consecutive write words.
  always_comb begin
    gather = '0;
    for (int k = 0; k < RATIO; k++) begin
      gather[k*WW +: WW] = mem[WA'((int'(raddr) << SH) + k)];
    end
    ram_d   = re ? gather : ram_q;
    rdata_d = regen ? ram_q : rdata_q;
  end

  always_ff @(posedge clk) begin
    ram_q   <= ram_d;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cmprs_chunk_fifo.sv
// rtl/cmprs_chunk_fifo.sv - chunked compressor output FIFO with multi-frame end tracking
// Optional: CMPRS_FIFO_STATS_EN adds max_count (high-water mark of fifo_count).
// Ports:
//   mclk, mrst      clock, synchronous active-high reset
//   we/wdata/wlast  stuffer word write; wlast closes the frame (partial chunk padded)
//   rst_fifo        discard all buffered data and frame ends
//   ren             read one 64-bit word; rdata/rvalid follow two cycles later
//   fifo_count      complete chunks stored
//   frame_chunks    chunks left to the end of the oldest queued frame
//   frames_pending  completed frames not fully read; flush_fifo = frames_pending != 0
//   eof_in/eof_out  frame end queued / oldest frame fully read (one-cycle pulses)
//   overflow        sticky: write while full or frame end while queue full
//   underrun        sticky: read while empty
module cmprs_chunk_fifo
  import cmprs_fifo_pkg::*;
#(
  parameter int LOG2WIDTH_WR     = 4,
  parameter int LOG2CHUNK_BYTES  = 5,
  parameter int LOG2DEPTH_CHUNKS = 7,
  parameter int LOG2FRAMES       = 2
) (
  input  logic                         mclk,
  input  logic                         mrst,
  input  logic                         we,
  input  logic [(1<<LOG2WIDTH_WR)-1:0] wdata,
  input  logic                         wlast,
  input  logic                         rst_fifo,
  input  logic                         ren,
  output logic [63:0]                  rdata,
  output logic                         rvalid,
  output logic [LOG2DEPTH_CHUNKS:0]    fifo_count,
  output logic [LOG2DEPTH_CHUNKS:0]    frame_chunks,
  output logic [LOG2FRAMES:0]          frames_pending,
  output logic                         flush_fifo,
  output logic                         eof_in,
  output logic                         eof_out,
  output logic                         overflow,
  output logic                         underrun
`ifdef CMPRS_FIFO_STATS_EN
  ,
  output logic [LOG2DEPTH_CHUNKS:0]    max_count
`endif
);
  localparam int WA  = wa_bits(LOG2WIDTH_WR, LOG2CHUNK_BYTES, LOG2DEPTH_CHUNKS);
  localparam int RA  = ra_bits(LOG2CHUNK_BYTES, LOG2DEPTH_CHUNKS);
  localparam int PW  = ptr_bits(LOG2DEPTH_CHUNKS);
  localparam int CW  = wsub_bits(LOG2WIDTH_WR, LOG2CHUNK_BYTES);
  localparam int CR  = rsub_bits(LOG2CHUNK_BYTES);
  localparam int WC  = WA - CW;
  localparam int FQ  = 1 << LOG2FRAMES;
  localparam int FW  = LOG2FRAMES + 1;
  localparam int FPW = LOG2FRAMES;
  localparam logic [PW-1:0] FULL_CNT = PW'(1 << LOG2DEPTH_CHUNKS);
  localparam logic [FW-1:0] FQ_FULL  = FW'(FQ);

  logic [WA-1:0]  waddr_q, waddr_d;
  logic [RA-1:0]  raddr_q, raddr_d;
  logic [PW-1:0]  wchunk_q, wchunk_d;
  logic [PW-1:0]  rchunk_q, rchunk_d;
  logic [PW-1:0]  fifo_count_q, fifo_count_d;
  logic [PW-1:0]  fq_q [FQ];
  logic [PW-1:0]  fq_d [FQ];
  logic [FPW-1:0] fq_wp_q, fq_wp_d;
  logic [FPW-1:0] fq_rp_q, fq_rp_d;
  logic [FW-1:0]  frames_pending_q, frames_pending_d;
  logic           overflow_q, overflow_d;
  logic           underrun_q, underrun_d;
  logic           eof_in_q, eof_in_d;
  logic           eof_out_q, eof_out_d;
  logic           ren_d1_q, ren_d1_d;
  logic           rvalid_q, rvalid_d;

  logic [CW-1:0]  wpos, wpos_next;
  logic [WC-1:0]  wcidx;
  logic [PW-1:0]  head;
  logic           full, empty, q_full, q_nonempty;
  logic           we_acc, ren_acc, wlast_eff;
  logic           chunk_done, chunk_read, push_acc, pop;

  always_comb begin
    wpos       = waddr_q[CW-1:0];
    wcidx      = waddr_q[WA-1:CW];
    full       = (fifo_count_q == FULL_CNT);
    empty      = (fifo_count_q == '0);
    q_full     = (frames_pending_q == FQ_FULL);
    q_nonempty = (frames_pending_q != '0);
    head       = fq_q[fq_rp_q];

    we_acc     = we & ~full & ~rst_fifo;
    ren_acc    = ren & ~empty & ~rst_fifo;
    wlast_eff  = wlast & ~rst_fifo;

    // wlast closes a partial chunk only if it is non-empty after this cycle's word.
    wpos_next  = wpos + CW'(we_acc);
    chunk_done = (we_acc && (wpos == {CW{1'b1}})) || (wlast_eff && (wpos_next != '0));
    chunk_read = ren_acc && (raddr_q[CR-1:0] == {CR{1'b1}});
    push_acc   = wlast_eff && !q_full;
    // Second term retires empty frames whose end already equals the read pointer.
    pop        = q_nonempty && !rst_fifo &&
                 ((chunk_read && ((rchunk_q + PW'(1)) == head)) || (head == rchunk_q));

    waddr_d          = waddr_q;
    raddr_d          = raddr_q + RA'(ren_acc);
    wchunk_d         = wchunk_q + PW'(chunk_done);
    rchunk_d         = rchunk_q + PW'(chunk_read);
    fifo_count_d     = fifo_count_q + PW'(chunk_done) - PW'(chunk_read);
    fq_d             = fq_q;
    fq_wp_d          = fq_wp_q + FPW'(push_acc);
    fq_rp_d          = fq_rp_q + FPW'(pop);
    frames_pending_d = frames_pending_q + FW'(push_acc) - FW'(pop);
    overflow_d       = overflow_q | (we & full) | (wlast & q_full);
    underrun_d       = underrun_q | (ren & empty);
    eof_in_d         = push_acc;
    eof_out_d        = pop;
    ren_d1_d         = ren_acc;
    rvalid_d         = ren_d1_q;

    if (chunk_done) begin
      waddr_d = {wcidx + WC'(1), {CW{1'b0}}};
    end else if (we_acc) begin
      waddr_d = waddr_q + WA'(1);
    end
    if (push_acc) fq_d[fq_wp_q] = wchunk_d;

    // Drop the partial chunk and line the read side up with the write chunk boundary.
    if (rst_fifo) begin
      waddr_d          = {wcidx, {CW{1'b0}}};
      raddr_d          = {wcidx, {CR{1'b0}}};
      wchunk_d         = wchunk_q;
      rchunk_d         = wchunk_q;
      fifo_count_d     = '0;
      fq_wp_d          = '0;
      fq_rp_d          = '0;
      frames_pending_d = '0;
      overflow_d       = 1'b0;
      underrun_d       = 1'b0;
      eof_in_d         = 1'b0;
      eof_out_d        = 1'b0;
      ren_d1_d         = 1'b0;
      rvalid_d         = 1'b0;
    end
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      waddr_q          <= '0;
      raddr_q          <= '0;
      wchunk_q         <= '0;
      rchunk_q         <= '0;
      fifo_count_q     <= '0;
      fq_wp_q          <= '0;
      fq_rp_q          <= '0;
      frames_pending_q <= '0;
      overflow_q       <= 1'b0;
      underrun_q       <= 1'b0;
      eof_in_q         <= 1'b0;
      eof_out_q        <= 1'b0;
      ren_d1_q         <= 1'b0;
      rvalid_q         <= 1'b0;
    end else begin
      waddr_q          <= waddr_d;
      raddr_q          <= raddr_d;
      wchunk_q         <= wchunk_d;
      rchunk_q         <= rchunk_d;
      fifo_count_q     <= fifo_count_d;
      fq_wp_q          <= fq_wp_d;
      fq_rp_q          <= fq_rp_d;
      frames_pending_q <= frames_pending_d;
      overflow_q       <= overflow_d;
      underrun_q       <= underrun_d;
      eof_in_q         <= eof_in_d;
      eof_out_q        <= eof_out_d;
      ren_d1_q         <= ren_d1_d;
      rvalid_q         <= rvalid_d;
    end
    fq_q <= fq_d;
  end

  cmprs_chunk_ram #(
    .LOG2WIDTH_WR (LOG2WIDTH_WR),
    .WA           (WA),
    .RA           (RA)
  ) u_ram (
    .clk   (mclk),
    .we    (we_acc),
    .waddr (waddr_q),
    .wdata (wdata),
    .re    (ren_acc),
    .raddr (raddr_q),
    .regen (ren_d1_q),
    .rdata (rdata)
  );

  assign rvalid         = rvalid_q;
  assign fifo_count     = fifo_count_q;
  assign frame_chunks   = q_nonempty ? (head - rchunk_q) : '0;
  assign frames_pending = frames_pending_q;
  assign flush_fifo     = q_nonempty;
  assign eof_in         = eof_in_q;
  assign eof_out        = eof_out_q;
  assign overflow       = overflow_q;
  assign underrun       = underrun_q;

`ifdef CMPRS_FIFO_STATS_EN
  logic [PW-1:0] max_count_q, max_count_d;

  always_comb begin
    max_count_d = max_count_q;
    if (rst_fifo) begin
      max_count_d = '0;
    end else if (fifo_count_q > max_count_q) begin
      max_count_d = fifo_count_q;
    end
  end

  always_ff @(posedge mclk) begin
    if (mrst) max_count_q <= '0;
    else      max_count_q <= max_count_d;
  end

  assign max_count = max_count_q;
`endif

endmodule

// File: tb/tb_cmprs_chunk_fifo.sv
// tb/tb_cmprs_chunk_fifo.sv - randomized self-checking bench for cmprs_chunk_fifo
module tb_cmprs_chunk_fifo;
  localparam int LD    = 7;
  localparam int LF    = 2;
  localparam int WPC   = 16;
  localparam int RPC   = 4;
  localparam int DEPTH = 128;
  localparam int NFQ   = 4;

  logic        mclk = 1'b0;
  logic        mrst, we, wlast, rst_fifo, ren;
  logic [15:0] wdata;
  logic [63:0] rdata;
  logic        rvalid, flush_fifo, eof_in, eof_out, overflow, underrun;
  logic [LD:0] fifo_count, frame_chunks;
  logic [LF:0] frames_pending;
`ifdef CMPRS_FIFO_STATS_EN
  logic [LD:0] max_count;
`endif

  cmprs_chunk_fifo dut (
    .mclk           (mclk),
    .mrst           (mrst),
    .we             (we),
    .wdata          (wdata),
    .wlast          (wlast),
    .rst_fifo       (rst_fifo),
    .ren            (ren),
    .rdata          (rdata),
    .rvalid         (rvalid),
    .fifo_count     (fifo_count),
    .frame_chunks   (frame_chunks),
    .frames_pending (frames_pending),
    .flush_fifo     (flush_fifo),
    .eof_in         (eof_in),
    .eof_out        (eof_out),
    .overflow       (overflow),
    .underrun       (underrun)
`ifdef CMPRS_FIFO_STATS_EN
    ,
    .max_count      (max_count)
`endif
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: words held in plain queues, chunk totals as unbounded integers.
  logic [16:0] m_words[$];  // bit 16 marks a real (non-pad) word
  logic [16:0] m_part[$];
  int          m_fq[$];     // total chunks written when each frame ended
  int          m_tw, m_tr, m_rpos, m_max;
  bit          m_ov, m_un, m_eof_in, m_eof_out;
  bit          p1_v, p2_v;
  logic [63:0] p1_d, p1_m, p2_d, p2_m;

  task automatic model_reset();
    m_words.delete(); m_part.delete(); m_fq.delete();
    m_tw = 0; m_tr = 0; m_rpos = 0; m_max = 0;
    m_ov = 0; m_un = 0; m_eof_in = 0; m_eof_out = 0;
    p1_v = 0; p2_v = 0; p1_d = '0; p1_m = '0; p2_d = '0; p2_m = '0;
  endtask

  task automatic flush_part();
    while (m_part.size() != 0) m_words.push_back(m_part.pop_front());
    m_tw++;
  endtask

  task automatic model_step(input bit iwe, input logic [15:0] iwd, input bit iwl,
                            input bit iren, input bit irf);
    int cnt, rd_before, pre_fq;
    bit pop;
    logic [16:0] w;
    p2_v = p1_v; p2_d = p1_d; p2_m = p1_m;
    p1_v = 0;
    if (irf) begin
      m_words.delete(); m_part.delete(); m_fq.delete();
      m_tr = m_tw; m_rpos = 0; m_max = 0;
      m_ov = 0; m_un = 0; m_eof_in = 0; m_eof_out = 0;
      p2_v = 0;
      return;
    end
    cnt = m_tw - m_tr;
    if (cnt > m_max) m_max = cnt;
    rd_before = m_tr;
    pre_fq = m_fq.size();
    if (iren) begin
      if (cnt == 0) m_un = 1;
      else begin
        p1_v = 1; p1_d = '0; p1_m = '0;
        for (int k = 0; k < 4; k++) begin
          w = m_words.pop_front();
          p1_d[16*k +: 16] = w[15:0];
          p1_m[16*k +: 16] = {16{w[16]}};
        end
        m_rpos++;
        if (m_rpos == RPC) begin m_rpos = 0; m_tr++; end
      end
    end
    if (iwe) begin
      if (cnt == DEPTH) m_ov = 1;
      else begin
        m_part.push_back({1'b1, iwd});
        if (m_part.size() == WPC) flush_part();
      end
    end
    if (iwl && m_part.size() != 0) begin
      while (m_part.size() < WPC) m_part.push_back(17'h0);
      flush_part();
    end
    pop = 0;
    if (pre_fq != 0) pop = (m_fq[0] == rd_before) || (m_fq[0] == m_tr);
    m_eof_in = 0;
    if (iwl) begin
      if (pre_fq == NFQ) m_ov = 1;
      else begin m_fq.push_back(m_tw); m_eof_in = 1; end
    end
    if (pop) void'(m_fq.pop_front());
    m_eof_out = pop;
  endtask

  task automatic compare();
    chk("fifo_count", 64'(fifo_count), 64'(m_tw - m_tr));
    chk("frames_pending", 64'(frames_pending), 64'(m_fq.size()));
    chk("frame_chunks", 64'(frame_chunks), (m_fq.size() != 0) ? 64'(m_fq[0] - m_tr) : 64'd0);
    chk("flush_fifo", 64'(flush_fifo), 64'(m_fq.size() != 0));
    chk("eof_in", 64'(eof_in), 64'(m_eof_in));
    chk("eof_out", 64'(eof_out), 64'(m_eof_out));
    chk("overflow", 64'(overflow), 64'(m_ov));
    chk("underrun", 64'(underrun), 64'(m_un));
    chk("rvalid", 64'(rvalid), 64'(p2_v));
    if (p2_v) chk("rdata", rdata & p2_m, p2_d & p2_m);
`ifdef CMPRS_FIFO_STATS_EN
    chk("max_count", 64'(max_count), 64'(m_max));
`endif
  endtask

  task automatic cyc(input bit iwe, input logic [15:0] iwd, input bit iwl,
                     input bit iren, input bit irf);
    we = iwe; wdata = iwd; wlast = iwl; ren = iren; rst_fifo = irf;
    model_step(iwe, iwd, iwl, iren, irf);
    @(posedge mclk);
    #1;
    compare();
  endtask

  task automatic wr(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame_end();
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clear_fifo();
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int n_eof, t_first, t_second, cyc_i;
    mrst = 1'b1; we = 1'b0; wdata = '0; wlast = 1'b0; rst_fifo = 1'b0; ren = 1'b0;
    model_reset();
    repeat (2) @(posedge mclk);
    #1;
    chk("reset_fifo_count", 64'(fifo_count), 64'd0);
    chk("reset_frames_pending", 64'(frames_pending), 64'd0);
    chk("reset_rvalid", 64'(rvalid), 64'd0);
    chk("reset_stickies", 64'({overflow, underrun, eof_in, eof_out}), 64'd0);
    mrst = 1'b0;

    // One full chunk, one frame.
    wr(16);
    frame_end();
    chk("tp1_count", 64'(fifo_count), 64'd1);
    chk("tp1_eof_in", 64'(eof_in), 64'd1);
    chk("tp1_frames", 64'(frames_pending), 64'd1);
    chk("tp1_flush", 64'(flush_fifo), 64'd1);
    rd(4);
    chk("tp1_eof_out", 64'(eof_out), 64'd1);
    chk("tp1_flush_clr", 64'(flush_fifo), 64'd0);
    idle(3);

    // Partial chunk padded by wlast.
    wr(5);
    frame_end();
    chk("tp2_count", 64'(fifo_count), 64'd1);
    rd(4);
    idle(3);

    // Frames of 2, 0 and 3 chunks.
    wr(32); frame_end(); frame_end(); wr(48); frame_end();
    idle(1);
    chk("tp3_frames", 64'(frames_pending), 64'd3);
    chk("tp3_frame_chunks", 64'(frame_chunks), 64'd2);
    n_eof = 0; t_first = -10; t_second = -10;
    for (cyc_i = 0; cyc_i < 26; cyc_i++) begin
      cyc(1'b0, 16'h0, 1'b0, cyc_i < 20, 1'b0);
      if (eof_out) begin
        n_eof++;
        if (n_eof == 1) t_first = cyc_i;
        if (n_eof == 2) t_second = cyc_i;
      end
    end
    chk("tp3_eof_count", 64'(n_eof), 64'd3);
    chk("tp3_empty_gap", 64'(t_second - t_first), 64'd1);

    // Randomized traffic: write-heavy then read-heavy.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        cyc($urandom_range(99) < ((ph == 0) ? 80 : 30), 16'($urandom),
            $urandom_range(99) < 3, $urandom_range(99) < ((ph == 0) ? 20 : 60),
            $urandom_range(999) < 2);
      end
    end

    // Fill to capacity, then one dropped word.
    clear_fifo();
    wr(DEPTH * WPC);
    chk("fill_count", 64'(fifo_count), 64'd128);
    chk("fill_no_ovf", 64'(overflow), 64'd0);
    wr(1);
    chk("full_ovf", 64'(overflow), 64'd1);
    chk("full_count", 64'(fifo_count), 64'd128);
    rd(4);
    wr(15);
    rd(3);
    cyc(1'b1, 16'($urandom), 1'b0, 1'b1, 1'b0);
    chk("same_cycle_count", 64'(fifo_count), 64'd127);
    idle(3);

    // Underrun, then rst_fifo mid-chunk, then a clean round trip.
    clear_fifo();
    rd(1);
    chk("underrun_set", 64'(underrun), 64'd1);
    wr(5);
    clear_fifo();
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_stickies", 64'({overflow, underrun}), 64'd0);
    wr(16);
    rd(4);
    idle(3);

`ifdef CMPRS_FIFO_STATS_EN
    clear_fifo();
    wr(40 * WPC);
    rd(40 * RPC);
    idle(3);
    chk("stats_max", 64'(max_count), 64'd40);
    clear_fifo();
    chk("stats_clear", 64'(max_count), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmprs_chunk_fifo.md
Name: cmprs_chunk_fifo

Overview:
Single-clock, parametrised successor of the compressor output FIFO.
- Accepts stuffer words of configurable width and buffers them as fixed-size chunks; the 64-bit read side feeds the AFI writer.
- Tracks multiple complete frames in flight, not just one.
- Signals per-frame EOF on the read side.
- Handles partial final chunks, overflow and underrun explicitly.

Parameters:
LOG2WIDTH_WR, 4, write word width = 1<<LOG2WIDTH_WR bits (4..6 legal).
LOG2CHUNK_BYTES, 5, chunk size in bytes (32 B default; 4..7 legal).
LOG2DEPTH_CHUNKS, 7, FIFO capacity = 1<<LOG2DEPTH_CHUNKS chunks.
LOG2FRAMES, 2, frame-end queue depth = 1<<LOG2FRAMES frames.

Ports:
mclk  input  1  single clock for all logic.
mrst  input  1  synchronous, active-high reset.
we  input  1  write strobe.
wdata  input  1<<LOG2WIDTH_WR  write data.
wlast  input  1  frame end; the word written in the same cycle (if any) belongs to this frame.
rst_fifo  input  1  discard contents: drop partial chunk, empty FIFO and frame queue.
ren  input  1  read one 64-bit word.
rdata  output  64  read data.
rvalid  output  1  rdata valid (ren delayed 2 cycles).
fifo_count  output  LOG2DEPTH_CHUNKS+1  complete chunks stored.
frame_chunks  output  LOG2DEPTH_CHUNKS+1  chunks left to the end of the oldest queued frame; 0 if the queue is empty.
frames_pending  output  LOG2FRAMES+1  completed frames not yet fully read.
flush_fifo  output  1  frames_pending != 0; reader must drain partial bursts.
eof_in  output  1  one-cycle pulse, frame end pushed to queue.
eof_out  output  1  one-cycle pulse, last chunk of oldest frame read (or empty frame popped).
overflow  output  1  sticky; cleared by mrst/rst_fifo.
underrun  output  1  sticky; cleared by mrst/rst_fifo.

Behaviour:
- Pointers:
  - waddr: write-word index, WA = LOG2DEPTH_CHUNKS+LOG2CHUNK_BYTES+3-LOG2WIDTH_WR bits.
  - raddr: 64-bit word index, RA = LOG2DEPTH_CHUNKS+LOG2CHUNK_BYTES-3 bits.
  - wchunk, rchunk: LOG2DEPTH_CHUNKS+1 bits each, wrap modulo 2^(LOG2DEPTH_CHUNKS+1).
- chunk_done: either
  - accepted we with waddr low chunk bits all ones, or
  - wlast with a nonzero partial chunk, after counting the same-cycle word. waddr rounds up to the next chunk boundary; pad bytes are undefined.
- chunk_read: accepted ren with raddr low chunk bits all ones.
- fifo_count: +1 on chunk_done only, -1 on chunk_read only, unchanged when both occur.
- Full: fifo_count == 2^LOG2DEPTH_CHUNKS. A we while full is dropped (waddr held, no memory write) and sets overflow.
- Empty: fifo_count == 0. A ren while empty is ignored (raddr held, rvalid stays 0) and sets underrun.
- Read latency 2: RAM output register plus regen; rvalid == ren accepted 2 cycles earlier.
- Frame queue:
  - wlast pushes the post-update wchunk (frame end pointer) and pulses eof_in the next cycle.
  - A push while the queue is full is dropped and sets overflow.
  - Empty frame (wlast with no new chunks): its end pointer equals the previous one; it pops the cycle after it reaches the head, pulsing eof_out.
- Head pop: when chunk_read makes rchunk+1 == head, or when head == rchunk. eof_out pulses on the registered pop.
- frame_chunks = head - rchunk (mod 2^(LOG2DEPTH_CHUNKS+1)).
- Same-cycle push and pop: frames_pending unchanged.
- rst_fifo (lower priority than mrst, higher than we/ren/wlast):
  - waddr low bits cleared; raddr set to waddr chunk boundary.
  - Counters, queue and stickies cleared; rvalid forced 0 next cycle.
- mrst: all pointers, counters and outputs 0; rdata undefined until first rvalid.

Optional Feature:
CMPRS_FIFO_STATS_EN
- Defined: adds output max_count (LOG2DEPTH_CHUNKS+1 bits).
  - Holds the high-water mark of fifo_count.
  - Cleared by mrst/rst_fifo.
  - Updated the cycle after fifo_count exceeds it.
- Undefined: port absent, no logic.

Decomposition:
- Package cmprs_fifo_pkg holds:
  - width functions for WA, RA and pointer widths;
  - chunk-index helpers.
- Sub-module cmprs_chunk_ram: simple dual-port RAM, write width 1<<LOG2WIDTH_WR, read width 64, registered output with regen, single clock.
- Pointer, count and frame-queue logic stays in the top module.

Test Plan:
- Defaults; write 16 words then wlast -> fifo_count=1, eof_in pulse, frames_pending=1, flush_fifo=1. Read 4 words -> rvalid 2 cycles after each ren, eof_out on 4th read+1, flush_fifo=0.
- Partial chunk: 5 words then wlast -> waddr=16, fifo_count=1; read 4 words, first 5x16-bit words match.
- Three frames of 2, 0 and 3 chunks queued -> frames_pending=3, frame_chunks=2. Drain -> eof_out three times; empty frame pops 1 cycle after first eof_out.
- Fill 128 chunks, write one more word -> write dropped, overflow=1, fifo_count=128. Same-cycle chunk_done and chunk_read at count 127 -> stays 127.
- ren with fifo_count=0 -> underrun=1, raddr unchanged. rst_fifo mid-chunk (waddr=0x25) -> waddr=0x20, raddr=0x8, all counts 0, stickies 0.
- With CMPRS_FIFO_STATS_EN: fill to 40, drain to 0 -> max_count=40; rst_fifo -> 0.
